// File: rtl/mc_ctrl.sv
// mc_ctrl -- multi-cycle MIPS control unit for the p5 CPU.
//
// Steps each instruction through FETCH / DECODE / EXEC / MEM / WB and drives
// the datapath strobes for the current state. Stalls on i_ready (FETCH) and
// d_ready (MEM) are timed by a saturating wait counter. Reaching MAX_WAIT with
// ready still low parks the unit in HALT with a sticky timeout flag. Only
// reset leaves HALT.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   Instr                 IR contents, valid from DECODE onward
//   i_ready, d_ready      instruction / data memory handshakes
//   br_taken              branch comparator result (beq equal, bgez rs>=0)
//   PCWrite, IRWrite      PC / IR load strobes
//   RegWrite              GRF write strobe
//   MemRead, MemWrite     DM access requests
//   RegDst, ALUSrc, MemtoReg, ExtOP, ALUctr   static datapath selects
//   nPC_sel               next-PC source (0 PC+4, 1 beq, 2 jal, 3 jr, 4 bgez)
//   state                 0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 5 HALT
//   timeout               sticky; set on entry to HALT
`timescale 1ns/1ps
module mc_ctrl #(
  parameter int NPC_SEL_W = 3,
  parameter int MAX_WAIT  = 15,
  parameter bit BGEZ_EN   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          Instr,
  input  logic                 i_ready,
  input  logic                 d_ready,
  input  logic                 br_taken,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic [1:0]           RegDst,
  output logic                 ALUSrc,
  output logic [1:0]           MemtoReg,
  output logic [NPC_SEL_W-1:0] nPC_sel,
  output logic [1:0]           ExtOP,
  output logic [1:0]           ALUctr,
  output logic [2:0]           state,
  output logic                 timeout
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP, OP_ADDU, OP_SUBU, OP_ORI, OP_LW, OP_LBU, OP_SW,
    OP_BEQ, OP_BGEZ, OP_LUI, OP_JAL, OP_JR
  } op_t;

  // A zero MAX_WAIT disables the timeout but still needs a 1-bit counter.
  localparam int               CNT_W   = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  state_t           cur_st, nxt_st;
  op_t              op;
  logic [CNT_W-1:0] wait_cnt;
  logic             stall;
  logic [5:0]       opcode, funct;
  logic [4:0]       rt;
  logic [1:0]       sel_rd, sel_mtr, sel_ext, sel_alu;
  logic             sel_asrc;
  logic             unused_instr;

  assign opcode       = Instr[31:26];
  assign rt           = Instr[20:16];
  assign funct        = Instr[5:0];
  assign unused_instr = ^{Instr[25:21], Instr[15:6]};
  assign state        = cur_st;

  // Instruction class; anything unrecognised falls through as a nop.
  always_comb begin
    op = OP_NOP;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b100001: op = OP_ADDU;
          6'b100011: op = OP_SUBU;
          6'b001000: op = OP_JR;
          default:   op = OP_NOP;
        endcase
      end
      6'b001101: op = OP_ORI;
      6'b100011: op = OP_LW;
      6'b100100: op = OP_LBU;
      6'b101011: op = OP_SW;
      6'b000100: op = OP_BEQ;
      6'b001111: op = OP_LUI;
      6'b000011: op = OP_JAL;
      6'b000001: if (BGEZ_EN && rt == 5'd1) op = OP_BGEZ;
      default:   op = OP_NOP;
    endcase
  end

  // Static selects, same encoding as the single-cycle controller.
  always_comb begin
    sel_rd   = 2'd0;
    sel_asrc = 1'b0;
    sel_mtr  = 2'd0;
    sel_ext  = 2'd0;
    sel_alu  = 2'd0;
    case (op)
      OP_ADDU: sel_rd = 2'd1;
      OP_SUBU: begin sel_rd = 2'd1; sel_alu = 2'd1; end
      OP_ORI:  begin sel_asrc = 1'b1; sel_ext = 2'd1; sel_alu = 2'd2; end
      OP_LW:   begin sel_asrc = 1'b1; sel_mtr = 2'd1; end
      OP_LBU:  begin sel_asrc = 1'b1; sel_mtr = 2'd1; sel_ext = 2'd2; end
      OP_SW:   sel_asrc = 1'b1;
      OP_BEQ:  sel_alu = 2'd1;
      OP_BGEZ: sel_alu = 2'd1;
      OP_LUI:  sel_mtr = 2'd2;
      OP_JAL:  begin sel_rd = 2'd2; sel_mtr = 2'd3; end
      default: ;
    endcase
  end

  // Next state; a stall at the wait limit diverts to HALT, but a ready
  // arriving in that same cycle takes the normal path.
  always_comb begin
    nxt_st = cur_st;
    stall  = 1'b0;
    case (cur_st)
      S_FETCH:  if (i_ready) nxt_st = S_DECODE; else stall = 1'b1;
      S_DECODE: nxt_st = (op == OP_NOP) ? S_FETCH : S_EXEC;
      S_EXEC: begin
        case (op)
          OP_LW, OP_LBU, OP_SW:           nxt_st = S_MEM;
          OP_ADDU, OP_SUBU, OP_ORI, OP_LUI: nxt_st = S_WB;
          default:                        nxt_st = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (d_ready) nxt_st = (op == OP_SW) ? S_FETCH : S_WB;
        else         stall  = 1'b1;
      end
      S_WB:    nxt_st = S_FETCH;
      default: nxt_st = S_HALT;
    endcase
    if (stall && (MAX_WAIT != 0) && (wait_cnt == CNT_LIM)) nxt_st = S_HALT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_st   <= S_FETCH;
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      cur_st <= nxt_st;
      if (nxt_st != cur_st)
        wait_cnt <= '0;
      else if (stall && wait_cnt != CNT_SAT)
        wait_cnt <= wait_cnt + 1'b1;
      if (nxt_st == S_HALT) timeout <= 1'b1;
    end
  end

  // Strobes follow the current state. Reset masks them combinationally, so
  // an in-flight access drops as soon as reset rises.
  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegDst   = 2'd0;
    ALUSrc   = 1'b0;
    MemtoReg = 2'd0;
    nPC_sel  = '0;
    ExtOP    = 2'd0;
    ALUctr   = 2'd0;
    if (!reset) begin
      if (cur_st inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
        RegDst   = sel_rd;
        ALUSrc   = sel_asrc;
        MemtoReg = sel_mtr;
        ExtOP    = sel_ext;
        ALUctr   = sel_alu;
      end
      case (cur_st)
        S_FETCH: begin
          PCWrite = i_ready;
          IRWrite = i_ready;
        end
        S_EXEC: begin
          case (op)
            OP_BEQ:  begin nPC_sel = NPC_SEL_W'(1); PCWrite = br_taken; end
            OP_BGEZ: begin nPC_sel = NPC_SEL_W'(4); PCWrite = br_taken; end
            OP_JR:   begin nPC_sel = NPC_SEL_W'(3); PCWrite = 1'b1; end
            OP_JAL:  begin nPC_sel = NPC_SEL_W'(2); PCWrite = 1'b1; RegWrite = 1'b1; end
            default: ;
          endcase
        end
        S_MEM: begin
          MemRead  = (op == OP_LW) || (op == OP_LBU);
          MemWrite = (op == OP_SW);
        end
        S_WB:    RegWrite = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
`timescale 1ns/1ps
module tb_mc_ctrl;

  localparam int MAXW = 15;

  localparam int C_NOP = 0, C_ADDU = 1, C_SUBU = 2, C_ORI = 3, C_LW = 4, C_LBU = 5,
                 C_SW = 6, C_BEQ = 7, C_BGEZ = 8, C_LUI = 9, C_JAL = 10, C_JR = 11;

  typedef struct packed {
    logic [2:0] st;
    logic       to;
    logic       pcw;
    logic       irw;
    logic       rw;
    logic       mr;
    logic       mw;
    logic [1:0] rd;
    logic       asrc;
    logic [1:0] mtr;
    logic [2:0] npc;
    logic [1:0] ext;
    logic [1:0] alu;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic        i_ready, d_ready, br_taken;
  logic        PCWrite, IRWrite, RegWrite, MemRead, MemWrite, ALUSrc, timeout;
  logic [1:0]  RegDst, MemtoReg, ExtOP, ALUctr;
  logic [2:0]  nPC_sel, state;
  obs_t        obs;

  int   n_cmp = 0;
  int   n_err = 0;
  obs_t  exp_q[$];
  string name_q[$];

  mc_ctrl #(.NPC_SEL_W(3), .MAX_WAIT(MAXW), .BGEZ_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .i_ready(i_ready), .d_ready(d_ready),
    .br_taken(br_taken), .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegDst(RegDst), .ALUSrc(ALUSrc),
    .MemtoReg(MemtoReg), .nPC_sel(nPC_sel), .ExtOP(ExtOP), .ALUctr(ALUctr),
    .state(state), .timeout(timeout)
  );

  always #5 clk = ~clk;

  assign obs = {state, timeout, PCWrite, IRWrite, RegWrite, MemRead, MemWrite,
                RegDst, ALUSrc, MemtoReg, nPC_sel, ExtOP, ALUctr};

  task automatic check(input obs_t act, input obs_t exp, input string nm);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h (state %0d) required %h (state %0d)",
               nm, act, act.st, exp, exp.st);
    end
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  always @(negedge clk) begin : mon
    obs_t  e;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      check(obs, e, n);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: instruction class and its static select values.
  function automatic int classify(input logic [31:0] i);
    logic [5:0] op, fn;
    logic [4:0] rt;
    op = i[31:26]; fn = i[5:0]; rt = i[20:16];
    if (op == 6'b000000) begin
      if (fn == 6'b100001) return C_ADDU;
      if (fn == 6'b100011) return C_SUBU;
      if (fn == 6'b001000) return C_JR;
      return C_NOP;
    end
    if (op == 6'b001101) return C_ORI;
    if (op == 6'b100011) return C_LW;
    if (op == 6'b100100) return C_LBU;
    if (op == 6'b101011) return C_SW;
    if (op == 6'b000100) return C_BEQ;
    if (op == 6'b001111) return C_LUI;
    if (op == 6'b000011) return C_JAL;
    if (op == 6'b000001 && rt == 5'd1) return C_BGEZ;
    return C_NOP;
  endfunction

  function automatic obs_t sels(input int c);
    obs_t s;
    s = '0;
    case (c)
      C_ADDU: s.rd = 2'd1;
      C_SUBU: begin s.rd = 2'd1; s.alu = 2'd1; end
      C_ORI:  begin s.asrc = 1'b1; s.ext = 2'd1; s.alu = 2'd2; end
      C_LW:   begin s.asrc = 1'b1; s.mtr = 2'd1; end
      C_LBU:  begin s.asrc = 1'b1; s.mtr = 2'd1; s.ext = 2'd2; end
      C_SW:   s.asrc = 1'b1;
      C_BEQ, C_BGEZ: s.alu = 2'd1;
      C_LUI:  s.mtr = 2'd2;
      C_JAL:  begin s.rd = 2'd2; s.mtr = 2'd3; end
      default: ;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] mk(input int k);
    logic [31:0] r;
    r = $urandom;
    case (k)
      0:  begin r[31:26] = 6'b000000; r[5:0] = 6'b100001; end
      1:  begin r[31:26] = 6'b000000; r[5:0] = 6'b100011; end
      2:  begin r[31:26] = 6'b000000; r[5:0] = 6'b001000; end
      3:  r[31:26] = 6'b001101;
      4:  r[31:26] = 6'b100011;
      5:  r[31:26] = 6'b100100;
      6:  r[31:26] = 6'b101011;
      7:  r[31:26] = 6'b000100;
      8:  begin r[31:26] = 6'b000001; r[20:16] = 5'd1; end
      9:  r[31:26] = 6'b001111;
      10: r[31:26] = 6'b000011;
      11: begin r[31:26] = 6'b000001; r[20:16] = 5'($urandom_range(2, 31)); end
      12: r[31:26] = 6'b111111;
      default: begin r[31:26] = 6'b000000; r[5:0] = 6'b101010; end
    endcase
    return r;
  endfunction

  task automatic push(input obs_t e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction: iw/dw stall cycles before i_ready/d_ready rise.
  // With rst_mem set, reset is pulsed during the second MEM cycle instead.
  task automatic do_instr(input logic [31:0] ins, input int iw, input int dw,
                          input logic br, input bit rst_mem, input string nm);
    int   c;
    obs_t e, s;
    c = classify(ins);
    s = sels(c);
    for (int k = 0; k <= iw; k++) begin
      i_ready = (k == iw); d_ready = 1'($urandom); br_taken = 1'($urandom);
      Instr = $urandom;
      e = '0; e.pcw = i_ready; e.irw = i_ready;
      push(e, {nm, "/fetch"}); step();
    end
    Instr = ins; i_ready = 1'($urandom); d_ready = 1'($urandom); br_taken = 1'($urandom);
    e = s; e.st = 3'd1;
    push(e, {nm, "/decode"}); step();
    if (c == C_NOP) return;
    i_ready = 1'($urandom); d_ready = 1'($urandom); br_taken = br;
    e = s; e.st = 3'd2;
    case (c)
      C_BEQ:  begin e.npc = 3'd1; e.pcw = br; end
      C_BGEZ: begin e.npc = 3'd4; e.pcw = br; end
      C_JR:   begin e.npc = 3'd3; e.pcw = 1'b1; end
      C_JAL:  begin e.npc = 3'd2; e.pcw = 1'b1; e.rw = 1'b1; end
      default: ;
    endcase
    push(e, {nm, "/exec"}); step();
    if (c == C_LW || c == C_LBU || c == C_SW) begin
      for (int k = 0; k <= dw; k++) begin
        d_ready = (k == dw); i_ready = 1'($urandom); br_taken = 1'($urandom);
        e = s; e.st = 3'd3; e.mr = (c != C_SW); e.mw = (c == C_SW);
        push(e, {nm, "/mem"});
        if (rst_mem && k == 1) begin
          @(negedge clk);
          #2 reset = 1'b1; i_ready = 1'b1;
          #1 check(obs, '0, {nm, "/reset_async"});
          step();
          check(obs, '0, {nm, "/reset_hold"});
          reset = 1'b0;
          return;
        end
        step();
      end
    end
    if (c == C_ADDU || c == C_SUBU || c == C_ORI || c == C_LUI || c == C_LW || c == C_LBU) begin
      i_ready = 1'($urandom); d_ready = 1'($urandom); br_taken = 1'($urandom);
      e = s; e.st = 3'd4; e.rw = 1'b1;
      push(e, {nm, "/wb"}); step();
    end
  endtask

  // i_ready never arrives: count runs 0..MAXW over MAXW+1 FETCH cycles, and
  // the cycle that sees count==MAXW with ready low moves to HALT.
  task automatic do_timeout();
    obs_t e;
    for (int k = 0; k <= MAXW; k++) begin
      i_ready = 1'b0; d_ready = 1'($urandom); br_taken = 1'($urandom); Instr = $urandom;
      e = '0;
      push(e, "timeout/fetch"); step();
    end
    for (int k = 0; k < 4; k++) begin
      i_ready = 1'($urandom); d_ready = 1'b1; br_taken = 1'b1;
      e = '0; e.st = 3'd5; e.to = 1'b1;
      push(e, "timeout/halt"); step();
    end
    reset = 1'b1; i_ready = 1'b1;
    #1 check(obs, '0, "timeout/reset");
    step();
    reset = 1'b0;
  endtask

  initial begin
    int iw, dw;
    reset = 1'b1; i_ready = 1'b1; d_ready = 1'b1; br_taken = 1'b1; Instr = 32'hFFFF_FFFF;
    #3 check(obs, '0, "reset_init");
    step();
    check(obs, '0, "reset_init_hold");
    reset = 1'b0;

    do_instr({6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100001}, 0, 0, 1'b0, 1'b0, "addu");
    do_instr({6'b100011, 5'd4, 5'd5, 16'h0010}, 0, 3, 1'b0, 1'b0, "lw_wait3");
    do_instr({6'b000100, 5'd1, 5'd2, 16'h0004}, 0, 0, 1'b0, 1'b0, "beq_nt");
    do_instr({6'b000100, 5'd1, 5'd2, 16'h0004}, 0, 0, 1'b1, 1'b0, "beq_t");
    do_instr({6'b000011, 26'h0000100}, 0, 0, 1'b0, 1'b0, "jal");
    do_instr({6'b000001, 5'd7, 5'd1, 16'hFFFC}, 2, 0, 1'b1, 1'b0, "bgez_t");
    do_instr({6'b000001, 5'd7, 5'd0, 16'hFFFC}, 0, 0, 1'b1, 1'b0, "bltz_nop");
    do_instr({6'b100100, 5'd4, 5'd5, 16'h0003}, MAXW, MAXW, 1'b0, 1'b0, "lbu_edge");
    do_instr({6'b101011, 5'd4, 5'd5, 16'h0008}, 1, 4, 1'b0, 1'b1, "sw_reset");
    do_instr(32'hFC00_0000, 0, 0, 1'b0, 1'b0, "nop_3f");

    for (int n = 0; n < 80; n++) begin
      iw = ($urandom_range(0, 7) == 0) ? MAXW : $urandom_range(0, 3);
      dw = ($urandom_range(0, 7) == 0) ? MAXW : $urandom_range(0, 3);
      do_instr(mk($urandom_range(0, 13)), iw, dw, 1'($urandom), 1'b0, "rand");
    end

    do_timeout();
    do_instr({6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100011}, 0, 0, 1'b0, 1'b0, "subu_after_halt");

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: actual %0d pending required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
